muldiv_unit: RTL and testbench

- Parametrised, multi-cycle RV32M/RV64M multiply/divide unit that takes all M-extension operations out of the single-cycle combinational ALU.
- Accepts one operation at a time over a valid/ready handshake and iterates one bit per cycle in a shared shift-add / restoring-divide datapath.
- Returns the result, with a caller tag, over a second valid/ready handshake.
- Sits beside the ALU in the execute stage; the pipeline stalls while the unit is busy.

---
 rtl/muldiv_pkg.sv | 38 +++
 rtl/muldiv_if.sv | 26 ++
 rtl/muldiv_iter_core.sv | 64 ++++++
 rtl/muldiv_unit.sv | 99 +++++++++
 tb/tb_muldiv_unit.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared op encodings, FSM states and op-classification helpers for the
// multi-cycle M-extension unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_rem(input logic [2:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_signed_a(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response handshake bundle between the execute stage and muldiv_unit.
interface muldiv_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/muldiv_iter_core.sv
// Unsigned iterative datapath: shift-add multiply or restoring divide, one bit
// per cycle. acc is the accumulator value after the current cycle's step.
module muldiv_iter_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              div_mode,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [2*XLEN-1:0] acc,
  output logic              done
);
  localparam int unsigned CW = $clog2(XLEN);

  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   b_q;
  logic [CW-1:0]     cnt;
  logic              running;
  logic              div_q;
  logic [XLEN:0]     add_sum;
  logic [XLEN:0]     rem_shift;
  logic [XLEN:0]     diff;

  // Multiply: {hi,lo} starts as {0,multiplier}, add-then-shift-right.
  // Divide:   {rem,quo} starts as {0,dividend}, shift-left-then-trial-subtract.
  always_comb begin
    add_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    rem_shift = acc_q[2*XLEN-1:XLEN-1];
    diff      = rem_shift - {1'b0, b_q};
    if (div_q) begin
      if (diff[XLEN]) acc = {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      else            acc = {diff[XLEN-1:0],      acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc = {add_sum, acc_q[XLEN-1:1]};
    end
  end

  assign done = running && (cnt == CW'(XLEN - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q   <= '0;
      b_q     <= '0;
      cnt     <= '0;
      running <= 1'b0;
      div_q   <= 1'b0;
    end else if (start) begin
      acc_q   <= {{XLEN{1'b0}}, a};
      b_q     <= b;
      cnt     <= '0;
      running <= 1'b1;
      div_q   <= div_mode;
    end else if (abort) begin
      running <= 1'b0;
    end else if (running) begin
      acc_q <= acc;
      cnt   <= cnt + 1'b1;
      if (done) running <= 1'b0;
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// RV32M/RV64M multi-cycle multiply/divide unit: sign handling, fast paths,
// handshake FSM around the unsigned iterative core.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    flush,
  muldiv_if.slave bus
);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state, state_n;
  logic [2:0]        op_q;
  logic              neg_q;
  logic [XLEN-1:0]   res_q;
  logic [TAG_W-1:0]  tag_q;

  logic              accept, sa, sb, div_zero, ovf, fast;
  logic [XLEN-1:0]   mag_a, mag_b, fast_result, calc_result;
  logic [2*XLEN-1:0] core_acc, prod;
  logic              core_done;

  assign accept   = bus.in_valid && (state == IDLE) && !flush;
  assign sa       = is_signed_a(bus.in_op) && bus.in_a[XLEN-1];
  assign sb       = is_signed_b(bus.in_op) && bus.in_b[XLEN-1];
  assign mag_a    = sa ? -bus.in_a : bus.in_a;
  assign mag_b    = sb ? -bus.in_b : bus.in_b;
  assign div_zero = is_div(bus.in_op) && (bus.in_b == '0);
  assign ovf      = is_div(bus.in_op) && is_signed_a(bus.in_op) &&
                    (bus.in_a == MIN_NEG) && (bus.in_b == '1);
  assign fast     = div_zero || ovf;

  always_comb begin
    fast_result = '0;
    if (div_zero) fast_result = is_rem(bus.in_op) ? bus.in_a : '1;
    else          fast_result = is_rem(bus.in_op) ? '0 : bus.in_a;
  end

  muldiv_iter_core #(.XLEN(XLEN)) u_core (
    .clk      (clk),
    .reset    (reset),
    .start    (accept && !fast),
    .abort    (flush),
    .div_mode (is_div(bus.in_op)),
    .a        (mag_a),
    .b        (mag_b),
    .acc      (core_acc),
    .done     (core_done)
  );

  always_comb begin
    prod        = neg_q ? -core_acc : core_acc;
    calc_result = '0;
    if (!is_div(op_q))     calc_result = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else if (is_rem(op_q)) calc_result = neg_q ? -core_acc[2*XLEN-1:XLEN] : core_acc[2*XLEN-1:XLEN];
    else                   calc_result = neg_q ? -core_acc[XLEN-1:0] : core_acc[XLEN-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = fast ? DONE : CALC;
      CALC:    if (flush) state_n = IDLE;
               else if (core_done) state_n = DONE;
      DONE:    if (flush || bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q  <= OP_MUL;
      neg_q <= 1'b0;
      res_q <= '0;
      tag_q <= '0;
    end else if (accept) begin
      op_q  <= bus.in_op;
      neg_q <= is_rem(bus.in_op) ? sa : (sa ^ sb);
      tag_q <= bus.in_tag;
      if (fast) res_q <= fast_result;
    end else if ((state == CALC) && core_done && !flush) begin
      res_q <= calc_result;
    end
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = (state == DONE);
  assign bus.out_result = res_q;
  assign bus.out_tag    = tag_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases, handshake/abort cases
// and randomized ops against a plain-arithmetic reference model.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic reset;
  logic flush;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  muldiv_if #(.XLEN(32), .TAG_W(5)) bus ();

  muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint     sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return '1; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return '1; p = ua / ub; return p[31:0]; end
      3'd6: begin if (b == 0) return a;  p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Called at posedge+1 with the unit idle; returns the result after hold
  // cycles of backpressure and completes the output handshake.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input int unsigned hold,
                        output logic [31:0] res, output logic [4:0] rtag,
                        output int unsigned lat);
    bus.in_op = op; bus.in_a = a; bus.in_b = b; bus.in_tag = tag; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.out_valid) check("timeout", bus.out_valid, 1'b1);
    res  = bus.out_result;
    rtag = bus.out_tag;
    repeat (hold) begin @(posedge clk); #1; end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("in_ready_after_done", bus.in_ready, 1'b1);
  endtask

  task automatic directed(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int unsigned exp_lat);
    logic [31:0] r;
    logic [4:0]  t, tg;
    int unsigned lat;
    tg = 5'($urandom_range(1, 31));
    run_op(op, a, b, tg, 0, r, t, lat);
    check({name, "_result"}, r, exp);
    check({name, "_tag"}, t, tg);
    if (exp_lat != 0) check({name, "_latency"}, lat, exp_lat);
  endtask

  task automatic expect_quiet(input string tag, input int unsigned cycles);
    int unsigned seen = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    logic [31:0] r, a, b, r0;
    logic [4:0]  t, tg, t0;
    logic [2:0]  op;
    int unsigned lat;

    reset = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_a = '0; bus.in_b = '0; bus.in_tag = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", bus.in_ready, 1'b1);
    check("reset_out_valid", bus.out_valid, 1'b0);
    check("reset_out_result", bus.out_result, 32'h0);
    check("reset_out_tag", bus.out_tag, 5'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    directed("mul_neg",    3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    directed("mulh_min",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    directed("mulhu_min",  3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
    directed("mulhsu_m1",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    directed("div_neg",    3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
    directed("rem_neg",    3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0);
    directed("divu",       3'b101, 32'd100,       32'd7,         32'd14,        0);
    directed("remu",       3'b111, 32'd100,       32'd7,         32'd2,         0);
    directed("divu_zero",  3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    directed("rem_zero",   3'b110, 32'd5,         32'd0,         32'd5,         1);
    directed("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    directed("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1);

    // Backpressure: result and tag must hold while out_ready stays low.
    bus.in_op = 3'b000; bus.in_a = 32'h1234; bus.in_b = 32'h10; bus.in_tag = 5'd9;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    check("bp_latency", lat, 33);
    repeat (10) begin
      @(posedge clk); #1;
      check("bp_valid_held", bus.out_valid, 1'b1);
      check("bp_result_held", bus.out_result, 32'h12340);
      check("bp_tag_held", bus.out_tag, 5'd9);
      check("bp_in_ready_low", bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp_in_ready_after", bus.in_ready, 1'b1);

    // Flush at CALC cycle 10.
    bus.in_op = 3'b001; bus.in_a = $urandom; bus.in_b = $urandom; bus.in_tag = 5'd3;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_calc_in_ready", bus.in_ready, 1'b1);
    expect_quiet("flush_calc_no_valid", 40);
    directed("mul_after_flush", 3'b000, 32'd3, 32'd4, 32'd12, 33);

    // Flush in DONE wins over a coincident out_ready.
    bus.in_op = 3'b101; bus.in_a = 32'd9; bus.in_b = 32'd0; bus.in_tag = 5'd4;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("flush_done_valid_before", bus.out_valid, 1'b1);
    flush = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; bus.out_ready = 1'b0;
    check("flush_done_valid", bus.out_valid, 1'b0);
    check("flush_done_in_ready", bus.in_ready, 1'b1);

    // Flush coincident with a request cancels the accept.
    bus.in_op = 3'b000; bus.in_a = 32'd5; bus.in_b = 32'd5; bus.in_tag = 5'd6;
    bus.in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; flush = 1'b0;
    check("flush_accept_in_ready", bus.in_ready, 1'b1);
    expect_quiet("flush_accept_no_valid", 40);

    // Reset at CALC cycle 5.
    bus.in_op = 3'b100; bus.in_a = 32'd1000; bus.in_b = 32'd3; bus.in_tag = 5'd17;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midreset_in_ready", bus.in_ready, 1'b1);
    check("midreset_out_valid", bus.out_valid, 1'b0);
    check("midreset_out_result", bus.out_result, 32'h0);
    check("midreset_out_tag", bus.out_tag, 5'h0);
    expect_quiet("midreset_no_valid", 40);

    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = rand_operand();
      b  = rand_operand();
      tg = 5'($urandom);
      run_op(op, a, b, tg, $urandom_range(0, 3), r, t, lat);
      check($sformatf("rand%0d_op%0d_result", i, op), r, ref_model(op, a, b));
      check($sformatf("rand%0d_tag", i), t, tg);
    end

    r0 = '0; t0 = '0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
